// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths and the write-back entry type.
//   DataWidth    - result / register width
//   RegAddrWidth - register address width
//   NumRegs      - architectural registers (scoreboard width)
//   wb_entry_t   - {rd, data} long-latency result
//   wb_src_e     - origin of the value on the register-file write port
package cpu_pkg;

  localparam int unsigned DataWidth    = 32;
  localparam int unsigned RegAddrWidth = 5;
  localparam int unsigned NumRegs      = 32;

  typedef struct packed {
    logic [RegAddrWidth-1:0] rd;
    logic [DataWidth-1:0]    data;
  } wb_entry_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LL  = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of wb_entry_t, Depth entries (power of 2, >=2).
//   clk, rst - clock (rising edge), asynchronous active-high reset
//   push     - write din (ignored when full)
//   pop      - drop head (ignored when empty)
//   din      - entry to write
//   full     - no free slot
//   empty    - no valid entry
//   head     - oldest entry (valid only when !empty)
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  localparam int unsigned PtrW = $clog2(Depth);

  wb_entry_t       mem [Depth];
  logic [PtrW:0]   wr_ptr;
  logic [PtrW:0]   rd_ptr;

  // Extra pointer MSB distinguishes full (MSBs differ) from empty (all equal).
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PtrW] != rd_ptr[PtrW]) &&
                 (wr_ptr[PtrW-1:0] == rd_ptr[PtrW-1:0]);
  assign head  = mem[rd_ptr[PtrW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + (PtrW+1)'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + (PtrW+1)'(1);
    end
  end

  // Storage needs no reset: pointer reset alone discards every entry.
  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[PtrW-1:0]] <= din;
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back stage merging ALU results (priority, no backpressure)
// and buffered long-latency results onto the register-file write port, with a
// per-register pending scoreboard for outstanding long-latency writes.
//   clk, rst          - clock (rising edge), asynchronous active-high reset
//   alu_valid/rd/data - single-cycle ALU result
//   alu_stall         - ALU must present alu_valid=0 this cycle
//   ll_valid/rd/data  - long-latency result offer; ll_ready = FIFO not full
//   issue_valid/rd    - long-latency op issued, marks rd pending
//   pending_mask      - bit r set while register r awaits a long-latency write
//   rf_write_*        - registered register-file write port
module wb_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned QueueDepth  = 4,
  parameter int unsigned StarveLimit = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_valid,
  input  logic [RegAddrWidth-1:0] alu_rd,
  input  logic [DataWidth-1:0]    alu_data,
  output logic                    alu_stall,
  input  logic                    ll_valid,
  output logic                    ll_ready,
  input  logic [RegAddrWidth-1:0] ll_rd,
  input  logic [DataWidth-1:0]    ll_data,
  input  logic                    issue_valid,
  input  logic [RegAddrWidth-1:0] issue_rd,
  output logic [NumRegs-1:0]      pending_mask,
  output logic                    rf_write_enable,
  output logic [RegAddrWidth-1:0] rf_write_address,
  output logic [DataWidth-1:0]    rf_write_data
);

  localparam int unsigned CntW = $clog2(StarveLimit + 1);

  logic               fifo_full;
  logic               fifo_empty;
  wb_entry_t          fifo_head;
  wb_entry_t          fifo_din;
  logic               fifo_push;
  logic               fifo_pop;
  logic               alu_win;
  logic               starve_hit;
  logic [CntW-1:0]    starve_cnt;
  wb_src_e            rf_src;
  logic [NumRegs-1:0] pending_next;

  assign ll_ready  = !fifo_full;
  assign fifo_push = ll_valid && ll_ready;
  assign fifo_din  = '{rd: ll_rd, data: ll_data};

  // During a stall cycle the ALU is locked out so the FIFO head goes through.
  assign alu_win    = alu_valid && (alu_rd != '0) && !alu_stall;
  assign fifo_pop   = !fifo_empty && !alu_win;
  assign starve_hit = alu_win && !fifo_empty &&
                      (starve_cnt == CntW'(StarveLimit - 1));

  wb_fifo #(
    .Depth (QueueDepth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Clear for the LL write on the port now, then set for a new issue: set wins.
  always_comb begin
    pending_next = pending_mask;
    if (rf_write_enable && (rf_src == SRC_LL))
      pending_next[rf_write_address] = 1'b0;
    if (issue_valid && (issue_rd != '0))
      pending_next[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt       <= '0;
      alu_stall        <= 1'b0;
      pending_mask     <= '0;
      rf_write_enable  <= 1'b0;
      rf_write_address <= '0;
      rf_write_data    <= '0;
      rf_src           <= SRC_ALU;
    end else begin
      alu_stall    <= starve_hit;
      pending_mask <= pending_next;

      if (alu_win && !fifo_empty && !starve_hit)
        starve_cnt <= starve_cnt + CntW'(1);
      else
        starve_cnt <= '0;

      rf_write_enable <= 1'b0;
      rf_src          <= SRC_ALU;
      if (alu_win) begin
        rf_write_enable  <= 1'b1;
        rf_write_address <= alu_rd;
        rf_write_data    <= alu_data;
      end else if (fifo_pop && (fifo_head.rd != '0)) begin
        rf_write_enable  <= 1'b1;
        rf_write_address <= fifo_head.rd;
        rf_write_data    <= fifo_head.data;
        rf_src           <= SRC_LL;
      end
    end
  end

  a_alu_not_pending: assert property (@(posedge clk) disable iff (rst)
    !(alu_valid && (alu_rd != '0) && pending_mask[alu_rd]));
  a_issue_not_pending: assert property (@(posedge clk) disable iff (rst)
    !(issue_valid && (issue_rd != '0) && pending_mask[issue_rd]));
  a_ll_pending: assert property (@(posedge clk) disable iff (rst)
    !(ll_valid && ll_ready && (ll_rd != '0) && !pending_mask[ll_rd]));

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  localparam int QD = 4;
  localparam int SL = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [31:0] pending_mask;
  logic        rf_write_enable;
  logic [4:0]  rf_write_address;
  logic [31:0] rf_write_data;

  wb_arbiter #(
    .QueueDepth  (QD),
    .StarveLimit (SL)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .alu_valid        (alu_valid),
    .alu_rd           (alu_rd),
    .alu_data         (alu_data),
    .alu_stall        (alu_stall),
    .ll_valid         (ll_valid),
    .ll_ready         (ll_ready),
    .ll_rd            (ll_rd),
    .ll_data          (ll_data),
    .issue_valid      (issue_valid),
    .issue_rd         (issue_rd),
    .pending_mask     (pending_mask),
    .rf_write_enable  (rf_write_enable),
    .rf_write_address (rf_write_address),
    .rf_write_data    (rf_write_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  int          lost;       // consecutive cycles the queue lost to the ALU
  logic        m_stall;
  logic        m_we;
  logic        m_src_ll;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] m_pend;
  logic [31:0] inq;        // pending regs whose result is already queued
  logic        had_entries;
  logic        was_full;
  logic        alu_takes;
  ent_t        e;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      lost = 0; m_stall = 0; m_we = 0; m_src_ll = 0;
      m_addr = 0; m_data = 0; m_pend = 0; inq = 0;
    end else begin
      had_entries = (q.size() != 0);
      was_full    = (q.size() == QD);
      if (m_we && m_src_ll) begin
        m_pend[m_addr] = 1'b0;
        inq[m_addr]    = 1'b0;
      end
      if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
      alu_takes = alu_valid && alu_rd != 0 && !m_stall;
      m_we = 0; m_src_ll = 0;
      if (alu_takes) begin
        m_we = 1; m_addr = alu_rd; m_data = alu_data;
      end else if (had_entries) begin
        e = q.pop_front();
        if (e.rd != 0) begin
          m_we = 1; m_src_ll = 1; m_addr = e.rd; m_data = e.data;
        end
      end
      if (had_entries && alu_takes) lost = lost + 1;
      else lost = 0;
      m_stall = (lost == SL);
      if (m_stall) lost = 0;
      if (ll_valid && !was_full) begin
        q.push_back('{rd: ll_rd, data: ll_data});
        if (ll_rd != 0) inq[ll_rd] = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("rf_we", {63'd0, rf_write_enable}, {63'd0, m_we});
    if (m_we) begin
      chk("rf_addr", {59'd0, rf_write_address}, {59'd0, m_addr});
      chk("rf_data", {32'd0, rf_write_data}, {32'd0, m_data});
    end
    chk("alu_stall", {63'd0, alu_stall}, {63'd0, m_stall});
    chk("ll_ready", {63'd0, ll_ready}, {63'd0, (q.size() < QD)});
    chk("pending", {32'd0, pending_mask}, {32'd0, m_pend});
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; ll_valid = 0; issue_valid = 0;
  endtask

  task automatic issue(input logic [4:0] r);
    idle();
    issue_valid = 1; issue_rd = r;
    step();
    issue_valid = 0;
  endtask

  function automatic logic [4:0] pick_free();
    logic [4:0] r;
    for (int t = 0; t < 64; t++) begin
      r = 5'($urandom_range(1, 31));
      if (!m_pend[r]) return r;
    end
    return 5'd0;
  endfunction

  function automatic logic [4:0] pick_ll();
    int c[$];
    for (int r = 1; r < 32; r++)
      if (m_pend[r] && !inq[r]) c.push_back(r);
    if (c.size() == 0 || $urandom_range(0, 7) == 0) return 5'd0;
    return 5'(c[$urandom_range(0, c.size() - 1)]);
  endfunction

  initial begin
    rst = 1;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ll_valid = 0; ll_rd = 0; ll_data = 0;
    issue_valid = 0; issue_rd = 0;

    // 1. reset state
    step(); step();
    chk("rst_we", {63'd0, rf_write_enable}, 64'd0);
    chk("rst_addr", {59'd0, rf_write_address}, 64'd0);
    chk("rst_data", {32'd0, rf_write_data}, 64'd0);
    chk("rst_stall", {63'd0, alu_stall}, 64'd0);
    chk("rst_pend", {32'd0, pending_mask}, 64'd0);
    rst = 0;
    step();
    chk("ready_after_rst", {63'd0, ll_ready}, 64'd1);

    // 2. ALU write, then ALU write to r0
    alu_valid = 1; alu_rd = 5; alu_data = 32'hA5A5_A5A5;
    step();
    chk("alu_we", {63'd0, rf_write_enable}, 64'd1);
    chk("alu_addr", {59'd0, rf_write_address}, 64'd5);
    chk("alu_data", {32'd0, rf_write_data}, 64'hA5A5_A5A5);
    alu_rd = 0;
    step();
    chk("alu_r0_we", {63'd0, rf_write_enable}, 64'd0);
    idle();

    // 3. issue -> push -> write -> pending clear
    issue(7);
    chk("pend7_set", {63'd0, pending_mask[7]}, 64'd1);
    step(); step();
    ll_valid = 1; ll_rd = 7; ll_data = 32'h1234;
    step();
    ll_valid = 0;
    chk("ll_no_bypass", {63'd0, rf_write_enable}, 64'd0);
    step();
    chk("ll_we", {63'd0, rf_write_enable}, 64'd1);
    chk("ll_addr", {59'd0, rf_write_address}, 64'd7);
    chk("ll_data", {32'd0, rf_write_data}, 64'h1234);
    chk("pend7_held", {63'd0, pending_mask[7]}, 64'd1);
    step();
    chk("pend7_clr", {63'd0, pending_mask[7]}, 64'd0);

    // 4. starvation: ALU busy every cycle, 4 LL pushes
    for (int r = 10; r < 14; r++) issue(5'(r));
    alu_valid = 1; alu_rd = 1; alu_data = 32'h0BAD_F00D;
    for (int k = 1; k <= 4; k++) begin
      ll_valid = 1; ll_rd = 5'(9 + k); ll_data = 32'h100 + k;
      step();
    end
    ll_valid = 0;
    chk("full_ready", {63'd0, ll_ready}, 64'd0);
    for (int k = 5; k <= 8; k++) begin
      chk("no_stall_yet", {63'd0, alu_stall}, 64'd0);
      step();
    end
    chk("stall_k8", {63'd0, alu_stall}, 64'd0);
    step();
    chk("stall", {63'd0, alu_stall}, 64'd1);
    chk("stall_cycle_alu_wr", {59'd0, rf_write_address}, 64'd1);
    alu_valid = 0;
    step();
    chk("stall_end", {63'd0, alu_stall}, 64'd0);
    chk("stall_ll_we", {63'd0, rf_write_enable}, 64'd1);
    chk("stall_ll_addr", {59'd0, rf_write_address}, 64'd10);
    chk("stall_ready", {63'd0, ll_ready}, 64'd1);
    for (int k = 11; k <= 13; k++) begin
      step();
      chk("drain_addr", {59'd0, rf_write_address}, 64'(k));
    end
    step(); step();

    // 5. simultaneous push/pop with 3 queued
    for (int r = 20; r < 24; r++) issue(5'(r));
    alu_valid = 1; alu_rd = 2; alu_data = 32'h2222;
    for (int k = 0; k < 3; k++) begin
      ll_valid = 1; ll_rd = 5'(20 + k); ll_data = 32'h2000 + k;
      step();
    end
    alu_valid = 0; ll_rd = 23; ll_data = 32'h2003;
    step();
    ll_valid = 0;
    chk("pp_ready", {63'd0, ll_ready}, 64'd1);
    chk("pp_addr0", {59'd0, rf_write_address}, 64'd20);
    for (int k = 21; k <= 23; k++) begin
      step();
      chk("pp_order", {59'd0, rf_write_address}, 64'(k));
    end
    step(); step();

    // 6. reset with queued entries
    issue(24); issue(25);
    alu_valid = 1; alu_rd = 3; alu_data = 32'h3333;
    ll_valid = 1; ll_rd = 24; ll_data = 32'h2424;
    step();
    ll_rd = 25; ll_data = 32'h2525;
    step();
    idle();
    rst = 1;
    step();
    chk("mid_rst_we", {63'd0, rf_write_enable}, 64'd0);
    chk("mid_rst_pend", {32'd0, pending_mask}, 64'd0);
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("flushed_we", {63'd0, rf_write_enable}, 64'd0);
    end

    // random phase
    for (int c = 0; c < 3000; c++) begin
      issue_valid = ($urandom_range(0, 9) < 3);
      issue_rd    = pick_free();
      alu_valid   = m_stall ? 1'b0 : ($urandom_range(0, 9) < 5);
      alu_rd      = ($urandom_range(0, 15) == 0) ? 5'd0 : pick_free();
      alu_data    = $urandom;
      ll_valid    = ($urandom_range(0, 9) < 5);
      ll_rd       = pick_ll();
      ll_data     = $urandom;
      step();
    end
    idle();
    repeat (10) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
